alu_dispatch_queue: RTL and testbench
=====================================

ALU_DISPATCH_QUEUE -- requirements
Module: alu_dispatch_queue

Interface
REQ-001 Parameter: IN_DEPTH, default 4, input operation FIFO entries (power of 2, >=2).
REQ-002 Parameter: OUT_DEPTH, default 4, result FIFO entries (power of 2, >=2).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  operation offered by the producer.
REQ-006 in_ready  output  1  input FIFO not full; transfer occurs when in_valid && in_ready.
REQ-007 in_a, in_b  input  8 each  operands.
REQ-008 in_opcode  input  4  [3:2] core select, [1:0] operation (00 add, 01 sub, 10 mul, 11 illegal).
REQ-009 alu_a, alu_b  output  8 each  registered operands to the multicore ALU.
REQ-010 alu_opcode  output  4  registered opcode to the multicore ALU.
REQ-011 alu_result  input  16  registered multicore result.
REQ-012 alu_core_flag  input  2  registered multicore core flag.
REQ-013 res_valid  output  1  result FIFO not empty.
REQ-014 res_ready  input  1  consumer accepts; pop when res_valid && res_ready.
REQ-015 res_data  output  16  head result; res_core  output  2  head core flag.
REQ-016 res_tag  output  3  head sequence tag; res_err  output  1  head op was illegal (opcode[1:0]==11).

Function
REQ-017 Input FIFO stores {a,b,opcode,tag}; the tag is a 3-bit counter that increments on each accepted op and wraps 7->0.
REQ-018 Pipeline: FIFO head -> ISSUE (alu_* regs, valid bit) -> WAIT (1 cycle while the multicore registers) -> CAPTURE (write alu_result/alu_core_flag/tag/err into the result FIFO).
REQ-019 Latency: an op accepted at edge N, with empty queues, reaches the ALU at edge N+1, is captured at edge N+3, and has res_valid=1 after edge N+3.
REQ-020 Issue fires at most one op per cycle, only when the input FIFO is non-empty and credits > 0.
REQ-021 Credits = OUT_DEPTH - (result FIFO occupancy + ops in ISSUE/WAIT); no captured result is ever dropped.
REQ-022 With no issue, alu_a/alu_b/alu_opcode hold their last values; the ISSUE valid bit clears.
REQ-023 res_err = 1 when the captured op had opcode[1:0]==11; res_data then carries alu_result unmodified (expected 0).
REQ-024 Simultaneous push and pop on a full input FIFO: in_ready=0, so no push occurs; simultaneous push and pop otherwise keeps occupancy constant.
REQ-025 A simultaneous capture and pop on the result FIFO is legal at any occupancy, including full.
REQ-026 FIFO pointers wrap modulo depth; full/empty are derived from an extra wrap bit.
REQ-027 In-order delivery: results leave in acceptance order, with consecutive tags modulo 8.
REQ-028 res_* outputs hold stable while res_valid && !res_ready.

Reset
REQ-029 rst asserted: both FIFOs empty, ISSUE/WAIT valid bits 0, tag counter 0, alu_a/alu_b/alu_opcode 0, res_valid 0, in_ready 0 during reset.
REQ-030 Reset mid-operation discards all in-flight and queued ops; no result for them ever appears.
REQ-031 in_ready = 1 on the first cycle after rst deasserts.

Verification
REQ-032 Single op: a=5, b=3, opcode=0000 -> after 3 edges res_valid=1, res_data=8, res_core=00, res_tag=0, res_err=0.
REQ-033 Back-to-back: push mul 200*200 (0110), then sub 3-5 (1001) -> res_data=40000/core 01/tag 0, then 0xFFFE/core 10/tag 1.
REQ-034 Backpressure: res_ready=0, push 10 ops -> 4 results queued, input FIFO fills, in_ready=0, no loss; raise res_ready -> all 10 drain in order, tags 0..7,0,1.
REQ-035 Illegal op: opcode=1111 -> res_err=1, res_data=0, res_core=11.
REQ-036 Reset with 3 ops in flight -> all outputs at reset values; next op pushed gets tag 0 and is the only result produced.
REQ-037 Full-throughput stream with res_ready=1 -> one result per cycle after 3-cycle fill; in_ready never drops.

Source files
------------

// File: rtl/alu_dispatch_queue.sv
// alu_dispatch_queue: buffers ALU operations, issues them in order to an
// external registered multicore ALU, and queues the results for a consumer.
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid/in_ready          producer handshake for {in_a, in_b, in_opcode}
//   in_opcode                  [3:2] core select, [1:0] op (add/sub/mul/illegal)
//   alu_a/alu_b/alu_opcode     registered operands driven to the multicore ALU
//   alu_result/alu_core_flag   registered multicore outputs, one cycle after issue
//   res_valid/res_ready        consumer handshake for the head result
//   res_data/res_core/res_tag  head result, core flag and 3-bit sequence tag
//   res_err                    head op used the illegal operation code
module alu_dispatch_queue #(
   parameter int unsigned IN_DEPTH  = 4,
   parameter int unsigned OUT_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_a,
   input  logic [7:0]  in_b,
   input  logic [3:0]  in_opcode,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [3:0]  alu_opcode,
   input  logic [15:0] alu_result,
   input  logic [1:0]  alu_core_flag,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_data,
   output logic [1:0]  res_core,
   output logic [2:0]  res_tag,
   output logic        res_err
);

   localparam int unsigned IAW = $clog2(IN_DEPTH);
   localparam int unsigned OAW = $clog2(OUT_DEPTH);
   localparam int unsigned CW  = OAW + 2;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [3:0] op;
      logic [2:0] tag;
   } in_entry_t;

   typedef struct packed {
      logic [15:0] data;
      logic [1:0]  core;
      logic [2:0]  tag;
      logic        err;
   } res_entry_t;

   in_entry_t  in_mem  [IN_DEPTH];
   res_entry_t res_mem [OUT_DEPTH];

   logic [IAW:0] in_wr, in_rd;
   logic [OAW:0] res_wr, res_rd;
   logic [2:0]   tag_cnt;

   logic         issue_v, wait_v;
   logic [2:0]   issue_tag, wait_tag;
   logic         issue_err, wait_err;

   logic         in_empty, in_full;
   logic         push, issue, pop;
   logic [OAW:0] res_cnt;
   logic [CW-1:0] in_flight;
   in_entry_t    in_head;
   res_entry_t   res_head;

   // FIFO status: equal pointers are empty, differing only in the wrap bit is full
   assign in_empty = (in_wr == in_rd);
   assign in_full  = (in_wr[IAW] != in_rd[IAW]) && (in_wr[IAW-1:0] == in_rd[IAW-1:0]);
   assign in_ready = ~rst & ~in_full;
   assign push     = in_valid & in_ready;
   assign in_head  = in_mem[in_rd[IAW-1:0]];

   // Credits count every slot already owed to the result FIFO, so a capture always fits
   assign res_cnt   = res_wr - res_rd;
   assign in_flight = CW'(res_cnt) + CW'(issue_v) + CW'(wait_v);
   assign issue     = ~in_empty & (in_flight < CW'(OUT_DEPTH));

   assign res_valid = (res_wr != res_rd);
   assign pop       = res_valid & res_ready;
   assign res_head  = res_mem[res_rd[OAW-1:0]];
   assign res_data  = res_head.data;
   assign res_core  = res_head.core;
   assign res_tag   = res_head.tag;
   assign res_err   = res_head.err;

   // Input FIFO storage
   always_ff @(posedge clk) begin
      if (push) begin
         in_mem[in_wr[IAW-1:0]] <= '{a: in_a, b: in_b, op: in_opcode, tag: tag_cnt};
      end
   end

   // Input FIFO pointers and sequence tag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         in_wr   <= '0;
         in_rd   <= '0;
         tag_cnt <= '0;
      end else begin
         if (push) begin
            in_wr   <= in_wr + (IAW+1)'(1);
            tag_cnt <= tag_cnt + 3'd1;
         end
         if (issue) begin
            in_rd <= in_rd + (IAW+1)'(1);
         end
      end
   end

   // ISSUE and WAIT stages; operand registers hold when nothing issues
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_v    <= 1'b0;
         issue_tag  <= '0;
         issue_err  <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_opcode <= '0;
         wait_v     <= 1'b0;
         wait_tag   <= '0;
         wait_err   <= 1'b0;
      end else begin
         issue_v <= issue;
         if (issue) begin
            alu_a      <= in_head.a;
            alu_b      <= in_head.b;
            alu_opcode <= in_head.op;
            issue_tag  <= in_head.tag;
            issue_err  <= (in_head.op[1:0] == 2'b11);
         end
         wait_v   <= issue_v;
         wait_tag <= issue_tag;
         wait_err <= issue_err;
      end
   end

   // Result FIFO: capture the multicore output one cycle after WAIT
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         res_wr <= '0;
         res_rd <= '0;
         for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
            res_mem[OAW'(i)] <= '0;
         end
      end else begin
         if (wait_v) begin
            res_mem[res_wr[OAW-1:0]] <= '{data: alu_result, core: alu_core_flag,
                                          tag: wait_tag, err: wait_err};
            res_wr <= res_wr + (OAW+1)'(1);
         end
         if (pop) begin
            res_rd <= res_rd + (OAW+1)'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_dispatch_queue.sv
// Self-checking bench for alu_dispatch_queue with a registered multicore stand-in.
module tb_alu_dispatch_queue;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_a = '0;
   logic [7:0]  in_b = '0;
   logic [3:0]  in_opcode = '0;
   logic [7:0]  alu_a, alu_b;
   logic [3:0]  alu_opcode;
   logic [15:0] alu_result;
   logic [1:0]  alu_core_flag;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [15:0] res_data;
   logic [1:0]  res_core;
   logic [2:0]  res_tag;
   logic        res_err;

   typedef struct packed {
      logic [15:0] data;
      logic [1:0]  core;
      logic [2:0]  tag;
      logic        err;
   } res_t;

   int   checks = 0;
   int   failures = 0;
   res_t exp_q[$];
   logic [2:0] m_tag = '0;

   always #5 clk = ~clk;

   alu_dispatch_queue #(.IN_DEPTH(4), .OUT_DEPTH(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_opcode(in_opcode),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_result(alu_result), .alu_core_flag(alu_core_flag),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_core(res_core), .res_tag(res_tag), .res_err(res_err)
   );

   // Multicore ALU stand-in: registers its result one cycle after the operands
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_result    <= '0;
         alu_core_flag <= '0;
      end else begin
         alu_core_flag <= alu_opcode[3:2];
         case (alu_opcode[1:0])
            2'b00:   alu_result <= {8'd0, alu_a} + {8'd0, alu_b};
            2'b01:   alu_result <= {8'd0, alu_a} - {8'd0, alu_b};
            2'b10:   alu_result <= alu_a * alu_b;
            default: alu_result <= '0;
         endcase
      end
   end

   // Expected result of one accepted op
   function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                  input logic [3:0] op, input logic [2:0] tag);
      res_t r;
      int   ia, ib, v;
      ia = int'(a);
      ib = int'(b);
      case (op[1:0])
         2'd0:    v = ia + ib;
         2'd1:    v = ia - ib;
         2'd2:    v = ia * ib;
         default: v = 0;
      endcase
      r.data = 16'(v);
      r.core = op[3:2];
      r.tag  = tag;
      r.err  = (op[1:0] == 2'd3);
      return r;
   endfunction

   // One cycle: drive at negedge, sample outputs, record acceptance in the model
   task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] op, input logic rr,
                       output logic acc, output logic popped, output logic rv,
                       output res_t got);
      @(negedge clk);
      in_valid  = v;
      in_a      = a;
      in_b      = b;
      in_opcode = op;
      res_ready = rr;
      acc    = v & in_ready;
      rv     = res_valid;
      popped = res_valid & rr;
      got    = {res_data, res_core, res_tag, res_err};
      if (acc) begin
         exp_q.push_back(model(a, b, op, m_tag));
         m_tag = m_tag + 3'd1;
      end
      @(posedge clk);
   endtask

   task automatic do_reset;
      @(negedge clk);
      in_valid  = 1'b0;
      res_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      m_tag = '0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
      checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid: got %b expected 0", res_valid); end
      checks++; if (alu_a !== 8'd0 || alu_b !== 8'd0) begin failures++; $display("FAIL reset_alu_ab: got %h/%h expected 00/00", alu_a, alu_b); end
      checks++; if (alu_opcode !== 4'd0) begin failures++; $display("FAIL reset_alu_opcode: got %h expected 0", alu_opcode); end
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
      exp_q.delete();
      m_tag = '0;
   endtask

   task automatic test_single;
      logic acc, pop, rv;
      res_t got, exp;
      int   first;
      do_reset();
      step(1'b1, 8'd5, 8'd3, 4'b0000, 1'b0, acc, pop, rv, got);
      checks++; if (acc !== 1'b1) begin failures++; $display("FAIL single_accept: got %b expected 1", acc); end
      first = 0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (k == 2) begin
            checks++;
            if (alu_a !== 8'd5 || alu_b !== 8'd3 || alu_opcode !== 4'd0) begin
               failures++; $display("FAIL single_issue: got %h %h %h expected 05 03 0", alu_a, alu_b, alu_opcode);
            end
         end
         if (res_valid === 1'b1 && first == 0) first = k;
      end
      checks++; if (first - 1 != 3) begin failures++; $display("FAIL single_latency: got %0d edges expected 3", first - 1); end
      step(1'b0, 8'd0, 8'd0, 4'd0, 1'b1, acc, pop, rv, got);
      checks++;
      if (!pop || exp_q.size() == 0) begin
         failures++; $display("FAIL single_result_missing: got popped=%b expected 1", pop);
      end else begin
         exp = exp_q.pop_front();
         if (got !== exp || got !== res_t'({16'd8, 2'b00, 3'd0, 1'b0})) begin
            failures++; $display("FAIL single_result: got %h expected %h", got, exp);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic acc, pop, rv;
      res_t got, exp;
      res_t want [2];
      int   npop;
      want[0] = {16'd40000, 2'b01, 3'd0, 1'b0};
      want[1] = {16'hFFFE,  2'b10, 3'd1, 1'b0};
      do_reset();
      step(1'b1, 8'd200, 8'd200, 4'b0110, 1'b1, acc, pop, rv, got);
      step(1'b1, 8'd3,   8'd5,   4'b1001, 1'b1, acc, pop, rv, got);
      npop = 0;
      for (int c = 0; c < 10; c++) begin
         step(1'b0, 8'd0, 8'd0, 4'd0, 1'b1, acc, pop, rv, got);
         if (pop) begin
            checks++;
            if (exp_q.size() == 0 || npop > 1) begin
               failures++; $display("FAIL b2b_extra: got %h expected none", got);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp || got !== want[npop]) begin
                  failures++; $display("FAIL b2b_result%0d: got %h expected %h", npop, got, want[npop]);
               end
            end
            npop++;
         end
      end
      checks++; if (npop != 2) begin failures++; $display("FAIL b2b_count: got %0d expected 2", npop); end
   endtask

   task automatic test_illegal;
      logic acc, pop, rv;
      res_t got, exp;
      int   npop;
      step(1'b1, 8'd77, 8'd9, 4'b1111, 1'b1, acc, pop, rv, got);
      npop = 0;
      for (int c = 0; c < 8; c++) begin
         step(1'b0, 8'd0, 8'd0, 4'd0, 1'b1, acc, pop, rv, got);
         if (pop) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL illegal_extra: got %h expected none", got);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp || got.err !== 1'b1 || got.data !== 16'd0 || got.core !== 2'b11) begin
                  failures++; $display("FAIL illegal_result: got %h expected %h", got, exp);
               end
            end
            npop++;
         end
      end
      checks++; if (npop != 1) begin failures++; $display("FAIL illegal_count: got %0d expected 1", npop); end
   endtask

   task automatic test_backpressure;
      logic [7:0] av [10];
      logic [7:0] bv [10];
      logic [3:0] ov [10];
      logic acc, pop, rv, have_snap;
      res_t got, exp, snap;
      int   j, idx, npop;
      for (int i = 0; i < 10; i++) begin
         av[i] = 8'($urandom);
         bv[i] = 8'($urandom);
         ov[i] = {2'($urandom), 2'($urandom_range(0, 2))};
      end
      do_reset();
      j = 0;
      have_snap = 1'b0;
      snap = '0;
      for (int c = 0; c < 20; c++) begin
         idx = (j < 10) ? j : 0;
         step(j < 10, av[idx], bv[idx], ov[idx], 1'b0, acc, pop, rv, got);
         if (acc) j++;
         if (rv) begin
            if (!have_snap) begin
               snap = got;
               have_snap = 1'b1;
            end else begin
               checks++;
               if (got !== snap) begin failures++; $display("FAIL bp_hold: got %h expected %h", got, snap); end
            end
         end
      end
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
      checks++; if (j != 8) begin failures++; $display("FAIL bp_accepted: got %0d expected 8", j); end
      checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL bp_res_valid: got %b expected 1", res_valid); end
      npop = 0;
      for (int c = 0; c < 60 && npop < 10; c++) begin
         idx = (j < 10) ? j : 0;
         step(j < 10, av[idx], bv[idx], ov[idx], 1'b1, acc, pop, rv, got);
         if (acc) j++;
         if (pop) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL bp_extra: got %h expected none", got);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp || got.tag !== 3'(npop)) begin
                  failures++; $display("FAIL bp_result%0d: got %h expected %h", npop, got, exp);
               end
            end
            npop++;
         end
      end
      checks++; if (npop != 10) begin failures++; $display("FAIL bp_drain_count: got %0d expected 10", npop); end
   endtask

   task automatic test_reset_midflight;
      logic acc, pop, rv;
      res_t got, exp;
      int   npop;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'($urandom), 8'($urandom), 4'b0100, 1'b0, acc, pop, rv, got);
      end
      step(1'b0, 8'd0, 8'd0, 4'd0, 1'b0, acc, pop, rv, got);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0 || res_valid !== 1'b0) begin failures++; $display("FAIL midrst_handshake: got in_ready=%b res_valid=%b expected 0 0", in_ready, res_valid); end
      checks++; if (alu_a !== 8'd0 || alu_b !== 8'd0 || alu_opcode !== 4'd0) begin failures++; $display("FAIL midrst_alu: got %h %h %h expected 00 00 0", alu_a, alu_b, alu_opcode); end
      exp_q.delete();
      m_tag = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_release: got %b expected 1", in_ready); end
      step(1'b1, 8'd21, 8'd4, 4'b1000, 1'b1, acc, pop, rv, got);
      npop = 0;
      for (int c = 0; c < 12; c++) begin
         step(1'b0, 8'd0, 8'd0, 4'd0, 1'b1, acc, pop, rv, got);
         if (pop) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL midrst_stale_result: got %h expected none", got);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp || got.tag !== 3'd0) begin
                  failures++; $display("FAIL midrst_result: got %h expected %h", got, exp);
               end
            end
            npop++;
         end
      end
      checks++; if (npop != 1) begin failures++; $display("FAIL midrst_count: got %0d expected 1", npop); end
   endtask

   task automatic test_stream;
      logic acc, pop, rv;
      res_t got, exp;
      do_reset();
      for (int i = 0; i < 44; i++) begin
         step(i < 40, 8'($urandom), 8'($urandom), 4'($urandom), 1'b1, acc, pop, rv, got);
         if (i < 40) begin
            checks++; if (acc !== 1'b1) begin failures++; $display("FAIL stream_in_ready@%0d: got %b expected 1", i, acc); end
         end
         checks++;
         if (pop !== (i >= 4)) begin failures++; $display("FAIL stream_rate@%0d: got popped=%b expected %b", i, pop, i >= 4); end
         if (pop) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL stream_extra: got %h expected none", got);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp) begin failures++; $display("FAIL stream_result@%0d: got %h expected %h", i, got, exp); end
            end
         end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL stream_leftover: got %0d expected 0", exp_q.size()); end
   endtask

   task automatic test_random;
      logic acc, pop, rv;
      res_t got, exp;
      do_reset();
      for (int i = 0; i < 340; i++) begin
         step((i < 300) && ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 4'($urandom),
              (i >= 300) || ($urandom_range(0, 3) != 0), acc, pop, rv, got);
         if (pop) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL random_extra: got %h expected none", got);
            end else begin
               exp = exp_q.pop_front();
               if (got !== exp) begin failures++; $display("FAIL random_result@%0d: got %h expected %h", i, got, exp); end
            end
         end
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL random_lost: got %0d outstanding expected 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_illegal();
      test_backpressure();
      test_reset_midflight();
      test_stream();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
